// File: rtl/alg_amba_vip_id_scheduler.sv
// Per-ID response scheduler: arbitrates 2**ID_WIDTH valid/ready streams onto one
// master stream, holding each grant for a whole burst or a programmable beat quota.
module alg_amba_vip_id_scheduler #(
    parameter  int DATA_WIDTH     = 128,
    parameter  int ID_WIDTH       = 5,
    parameter  int MAX_BEATS_LOG2 = 4,
    localparam int N              = 2**ID_WIDTH
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           cfg_mode,
    input  logic [MAX_BEATS_LOG2-1:0]      cfg_max_beats,
    input  logic [N-1:0]                   cfg_enable_mask,
    input  logic [N-1:0]                   s_valid,
    input  logic [N-1:0][DATA_WIDTH-1:0]   s_data,
    input  logic [N-1:0]                   s_last,
    output logic [N-1:0]                   s_ready,
    output logic                           m_valid,
    output logic [ID_WIDTH-1:0]            m_id,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last,
    input  logic                           m_ready,
    output logic                           busy,
    output logic [31:0]                    stat_grants
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [ID_WIDTH-1:0]       r_grant;
    logic [ID_WIDTH-1:0]       r_rr_ptr;
    logic [MAX_BEATS_LOG2-1:0] r_beat_cnt;
    logic [31:0]               r_stat_grants;

    logic [N-1:0]              w_req;
    logic [2*N-1:0]            w_req_dbl;
    logic [N-1:0]              w_req_rot;
    logic [ID_WIDTH-1:0]       w_winner;
    logic                      w_hs;
    logic [MAX_BEATS_LOG2:0]   w_beat_next;
    logic                      w_quota_hit;
    logic                      w_release;

    function automatic logic [ID_WIDTH-1:0] f_lowest(input logic [N-1:0] vec);
        f_lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) f_lowest = ID_WIDTH'(i);
        end
    endfunction

    // Round-robin rotates the request vector so rr_ptr sits at bit 0, then the
    // lowest set bit plus rr_ptr (mod N) is the winner.
    assign w_req     = s_valid & cfg_enable_mask;
    assign w_req_dbl = {w_req, w_req};
    assign w_req_rot = w_req_dbl[r_rr_ptr +: N];
    assign w_winner  = cfg_mode ? f_lowest(w_req)
                                : (f_lowest(w_req_rot) + r_rr_ptr);

    // One extra bit keeps beat_cnt + 1 from wrapping into a false quota match.
    assign w_beat_next = {1'b0, r_beat_cnt} + (MAX_BEATS_LOG2 + 1)'(1);
    assign w_quota_hit = (cfg_max_beats != '0) && (w_beat_next == {1'b0, cfg_max_beats});

    assign busy        = (r_state == GRANT);
    assign m_valid     = busy & s_valid[r_grant];
    assign m_id        = r_grant;
    assign m_data      = s_data[r_grant];
    assign m_last      = s_last[r_grant];
    assign w_hs        = m_valid & m_ready;
    assign w_release   = w_hs & (s_last[r_grant] | w_quota_hit);
    assign stat_grants = r_stat_grants;

    always_comb begin
        // NOTE: default first so no path through this block leaves s_ready unassigned (no latch).
        s_ready = '0;
        if (busy) s_ready[r_grant] = m_ready;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_stat_grants <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                        if (r_stat_grants != 32'hFFFF_FFFF)
                            r_stat_grants <= r_stat_grants + 32'd1;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_rr_ptr   <= r_grant + ID_WIDTH'(1);
                        r_beat_cnt <= '0;
                    end else if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + MAX_BEATS_LOG2'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alg_amba_vip_id_scheduler.md
# alg_amba_vip_id_scheduler

Per-ID output scheduler for the AMBA VIP response channel. It arbitrates between 2**ID_WIDTH per-ID valid/ready streams, typically the outputs of the per-ID interleaving latency stages, onto a single master stream. A grant is held for a whole burst (up to `last`) or for a programmable beat quota, whichever comes first. Arbitration is round-robin or fixed-priority, restricted by an enable mask, and the block counts grants for the test bench.

## Interface
Parameters:
- DATA_WIDTH, 128, payload width per ID stream.
- ID_WIDTH, 5, ID width; number of requesters N = 2**ID_WIDTH.
- MAX_BEATS_LOG2, 4, width of the beat-quota counter and of cfg_max_beats.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_mode  in  1  0 = round-robin, 1 = fixed priority (lowest ID wins).
- cfg_max_beats  in  MAX_BEATS_LOG2  beat quota per grant; 0 = no quota (release on last only).
- cfg_enable_mask  in  N  per-ID request enable; a disabled ID is never granted.
- s_valid  in  N  per-ID valid.
- s_data  in  N x DATA_WIDTH  per-ID payload (packed array).
- s_last  in  N  per-ID end-of-burst flag.
- s_ready  out  N  per-ID ready.
- m_valid  out  1  output valid.
- m_id  out  ID_WIDTH  ID of the granted stream.
- m_data  out  DATA_WIDTH  granted payload.
- m_last  out  1  granted last flag.
- m_ready  in  1  output ready.
- busy  out  1  high while a grant is held.
- stat_grants  out  32  number of grants issued, saturating at 32'hFFFFFFFF.

## Operation
- FSM states: IDLE and GRANT. Registers: state, grant[ID_WIDTH-1:0], rr_ptr[ID_WIDTH-1:0], beat_cnt[MAX_BEATS_LOG2-1:0], stat_grants.
- Request vector: req = s_valid & cfg_enable_mask. It is evaluated only in IDLE.
- Winner selection, round-robin: the first set bit of req scanning rr_ptr, rr_ptr+1, … , N-1, 0, … with wrap-around.
- Winner selection, fixed priority: the lowest set bit of req.
- IDLE with req != 0:
  - grant <= winner; beat_cnt <= 0; state <= GRANT.
  - stat_grants increments, but stays at 32'hFFFFFFFF once reached.
- IDLE with req == 0: the block holds its state.
- GRANT datapath:
  - m_valid = s_valid[grant]; m_data = s_data[grant]; m_last = s_last[grant]; m_id = grant.
  - s_ready[grant] = m_ready; every other s_ready bit is 0.
- Handshake: hs = m_valid & m_ready. On each hs, beat_cnt increments modulo 2**MAX_BEATS_LOG2.
- Release condition: hs & (s_last[grant] | (cfg_max_beats != 0 & beat_cnt + 1 == cfg_max_beats)).
  - The comparison is done in MAX_BEATS_LOG2 + 1 bits so that no wrap-around false match can occur.
- On release: state <= IDLE; rr_ptr <= grant + 1 (wraps from N-1 to 0); beat_cnt <= 0.
- In GRANT, if s_valid[grant] is low, the block waits and keeps the grant. There is no timeout.
- cfg_enable_mask and cfg_mode are sampled only in IDLE. Changing them mid-grant does not abort the current burst.
- A quota release in mid-burst is legal. The remaining beats of that ID compete again later.
- busy = (state == GRANT).
- In IDLE: m_valid = 0, s_ready = 0, and m_id/m_data/m_last present the last grant with m_valid low.

## Timing
- Reset values: state = IDLE, grant = 0, rr_ptr = 0, beat_cnt = 0, stat_grants = 0. The outputs follow: m_valid = 0, s_ready = 0, m_id = 0, busy = 0.
- Reset is asynchronous in both directions: asserting resetn mid-burst returns to IDLE immediately and drops m_valid and s_ready in the same cycle.
- Latency: s_valid rising in cycle T (in IDLE) gives m_valid high in cycle T+1, with the data passed combinationally from s_data.
- Each release costs one IDLE bubble cycle before the next grant. Peak throughput is B/(B+1) for bursts of B beats.
- The m_* outputs are combinational from the registered grant. There is no added register stage, so s->m latency is 0 within a grant.
- Output stability: while m_valid=1 and m_ready=0, m_id is stable. m_data is stable as long as the source holds its data (AXI rule on the inputs).
- Simultaneous requests are resolved by the selection rule in a single cycle. A new request arriving in the release cycle is considered in the following IDLE cycle.

## Test plan
- Single requester:
  - Stimulus: ID 3 sends a 4-beat burst, m_ready=1, cfg_max_beats=0, mask all ones.
  - Required: m_valid high from T+1 for 4 cycles with m_id=3; m_last on beat 4; busy then drops; stat_grants=1.
- Round-robin fairness:
  - Stimulus: IDs 0, 5 and 31 each hold continuous single-beat bursts (last=1), cfg_mode=0.
  - Required: grant order 0, 5, 31, 0, 5, …, one beat every 2 cycles.
- Fixed priority:
  - Stimulus: IDs 2 and 7 both continuously valid, cfg_mode=1.
  - Required: only ID 2 is granted. After s_valid[2] is deasserted, ID 7 is granted.
- Beat quota:
  - Stimulus: ID 1 sends an 8-beat burst, ID 4 sends 1 beat, cfg_max_beats=3, round-robin.
  - Required: sequence of 3 beats ID 1, 1 beat ID 4, 3 beats ID 1, then 2 beats ID 1 with m_last.
- Backpressure and mask:
  - Stimulus: m_ready toggles 1010 during a grant to ID 6; cfg_enable_mask bit 6 is cleared mid-burst.
  - Required: m_id and m_data stay stable while m_ready=0; the burst completes; ID 6 is then never granted again.
- Reset mid-burst:
  - Stimulus: assert resetn=0 on beat 2 of a 4-beat burst.
  - Required: m_valid, s_ready and busy are 0 immediately; stat_grants=0; after release, a new request is granted from rr_ptr=0.
